// File: rtl/axis_write_core_pkg.sv
// axis_write_core_pkg: shared constants, FSM encoding and helpers for the AXI write engine.
// Optional macro AXIS_WRITE_4K_SPLIT_EN (used by axis_burst_plan) adds 4 KB burst splitting.
`default_nettype none
package axis_write_core_pkg;
   localparam int BOUNDARY_4K    = 4096;
   localparam int BYTES_PER_BEAT = 4;
   localparam int MAX_BURST      = 256;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   function automatic int bytes_per_beat(input int axi_data_width);
      return axi_data_width / 8;
   endfunction
endpackage
`default_nettype wire

// File: rtl/axis_burst_plan.sv
// axis_burst_plan: beats in the next burst from current address and remaining beats.
// With AXIS_WRITE_4K_SPLIT_EN defined, bursts also stop at the next 4096-byte boundary.
`default_nettype none
module axis_burst_plan
   import axis_write_core_pkg::*;
#(
   parameter int CONFIG_DWIDTH  = 32,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int MAX_BEATS      = MAX_BURST,
   parameter int BEAT_BYTES     = BYTES_PER_BEAT
) (
   input  logic [AXI_ADDR_WIDTH-1:0] address,
   input  logic [CONFIG_DWIDTH-1:0]  remaining,
   output logic [CONFIG_DWIDTH-1:0]  beats
);
   localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
   localparam logic [CONFIG_DWIDTH-1:0] MAX_BEATS_C = CONFIG_DWIDTH'(MAX_BEATS);

   logic unused_address;
   assign unused_address = ^address;

`ifdef AXIS_WRITE_4K_SPLIT_EN
   logic [12:0]              bytes_to_boundary;
   logic [CONFIG_DWIDTH-1:0] beats_to_boundary;

   always_comb begin
      bytes_to_boundary = 13'(BOUNDARY_4K) - {1'b0, address[11:0]};
      beats_to_boundary = CONFIG_DWIDTH'(bytes_to_boundary >> BEAT_SHIFT);
      beats = (remaining < MAX_BEATS_C) ? remaining : MAX_BEATS_C;
      if (beats_to_boundary < beats) beats = beats_to_boundary;
   end
`else
   always_comb begin
      beats = (remaining < MAX_BEATS_C) ? remaining : MAX_BEATS_C;
   end
`endif
endmodule
`default_nettype wire

// File: rtl/axis_write_core.sv
// axis_write_core: turns {address, length} commands plus a word stream into AXI AW/W traffic.
// Optional macro AXIS_WRITE_4K_SPLIT_EN splits bursts at 4 KB boundaries.
`default_nettype none
module axis_write_core
   import axis_write_core_pkg::*;
#(
   parameter int BUF_AWIDTH     = 9,
   parameter int CONFIG_DWIDTH  = 32,
   parameter int WIDTH_RATIO    = 1,
   parameter int CONVERT_SHIFT  = 0,
   parameter int AXI_LEN_WIDTH  = 8,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int DATA_WIDTH     = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CONFIG_DWIDTH-1:0]  cfg_address,
   input  logic [CONFIG_DWIDTH-1:0]  cfg_length,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic                      axi_awready,
   output logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
   output logic [AXI_LEN_WIDTH-1:0]  axi_awlen,
   output logic                      axi_awvalid,
   output logic                      axi_wlast,
   output logic [AXI_DATA_WIDTH-1:0] axi_wdata,
   output logic                      axi_wvalid,
   input  logic                      axi_wready,
   input  logic [DATA_WIDTH-1:0]     data,
   input  logic                      valid,
   output logic                      ready
);
   localparam int BEAT_BYTES = bytes_per_beat(AXI_DATA_WIDTH);
   localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
   localparam int DEPTH      = 2 ** BUF_AWIDTH;
   localparam int IDX_W      = (CONVERT_SHIFT > 0) ? CONVERT_SHIFT : 1;
   localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(WIDTH_RATIO - 1);
   localparam logic [CONFIG_DWIDTH-1:0] ONE      = CONFIG_DWIDTH'(1);

   state_t state, state_next;
   logic [CONFIG_DWIDTH-1:0]  aw_remaining, aw_beats, w_remaining, w_beats, w_burst_left, words_left;
   logic [CONFIG_DWIDTH:0]    beats_sum;
   logic [CONFIG_DWIDTH-1:0]  total_beats;
   logic [AXI_ADDR_WIDTH-1:0] aw_addr_next, w_addr;
   logic [IDX_W-1:0]          pack_idx;
   logic [AXI_DATA_WIDTH-1:0] pack_reg, beat_data;
   logic [AXI_DATA_WIDTH-1:0] fifo_mem [DEPTH];
   logic [BUF_AWIDTH:0]       wr_ptr, rd_ptr;
   logic fifo_empty, fifo_full, accept, word_fire, push, pop, aw_load, aw_done, w_done, w_first;

   assign beats_sum   = {1'b0, cfg_length} + (CONFIG_DWIDTH + 1)'(WIDTH_RATIO - 1);
   assign total_beats = CONFIG_DWIDTH'(beats_sum >> CONVERT_SHIFT);

   assign cfg_ready  = (state == IDLE);
   assign accept     = cfg_valid & cfg_ready;
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[BUF_AWIDTH] != rd_ptr[BUF_AWIDTH]) &&
                       (wr_ptr[BUF_AWIDTH-1:0] == rd_ptr[BUF_AWIDTH-1:0]);
   assign ready      = (state == ACTIVE) && (words_left != '0) && !fifo_full;
   assign word_fire  = valid & ready;
   assign push       = word_fire && ((pack_idx == LAST_IDX) || (words_left == ONE));
   assign axi_wvalid = !fifo_empty;
   assign axi_wdata  = fifo_empty ? '0 : fifo_mem[rd_ptr[BUF_AWIDTH-1:0]];
   assign pop        = axi_wvalid & axi_wready;
   assign aw_load    = (state == ACTIVE) && (aw_remaining != '0) && (!axi_awvalid || axi_awready);
   assign aw_done    = (aw_remaining == '0) && !axi_awvalid;
   assign w_done     = (w_remaining == '0) && (w_burst_left == '0);
   // W beat counter re-plans a burst whenever the previous one has been fully sent.
   assign w_first    = (w_burst_left == '0);
   assign axi_wlast  = axi_wvalid && (w_first ? (w_beats == ONE) : (w_burst_left == ONE));

   axis_burst_plan #(
      .CONFIG_DWIDTH (CONFIG_DWIDTH),
      .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
      .MAX_BEATS     (2 ** AXI_LEN_WIDTH),
      .BEAT_BYTES    (BEAT_BYTES)
   ) u_aw_plan (
      .address  (aw_addr_next),
      .remaining(aw_remaining),
      .beats    (aw_beats)
   );

   axis_burst_plan #(
      .CONFIG_DWIDTH (CONFIG_DWIDTH),
      .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
      .MAX_BEATS     (2 ** AXI_LEN_WIDTH),
      .BEAT_BYTES    (BEAT_BYTES)
   ) u_w_plan (
      .address  (w_addr),
      .remaining(w_remaining),
      .beats    (w_beats)
   );

   always_comb begin
      beat_data = pack_reg;
      for (int i = 0; i < WIDTH_RATIO; i++) begin
         if (pack_idx == IDX_W'(i)) beat_data[i*DATA_WIDTH +: DATA_WIDTH] = data;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept && (total_beats != '0)) state_next = ACTIVE;
         ACTIVE:  if (aw_done && w_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[BUF_AWIDTH-1:0]] <= beat_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         aw_remaining <= '0;
         w_remaining  <= '0;
         w_burst_left <= '0;
         words_left   <= '0;
         aw_addr_next <= '0;
         w_addr       <= '0;
         pack_idx     <= '0;
         pack_reg     <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         axi_awvalid  <= 1'b0;
         axi_awaddr   <= '0;
         axi_awlen    <= '0;
      end else begin
         if (accept) begin
            aw_remaining <= total_beats;
            w_remaining  <= total_beats;
            w_burst_left <= '0;
            words_left   <= cfg_length;
            aw_addr_next <= AXI_ADDR_WIDTH'(cfg_address);
            w_addr       <= AXI_ADDR_WIDTH'(cfg_address);
            pack_idx     <= '0;
            pack_reg     <= '0;
         end

         if (aw_load) begin
            axi_awvalid  <= 1'b1;
            axi_awaddr   <= aw_addr_next;
            axi_awlen    <= AXI_LEN_WIDTH'(aw_beats - ONE);
            aw_remaining <= aw_remaining - aw_beats;
            aw_addr_next <= aw_addr_next + (AXI_ADDR_WIDTH'(aw_beats) << BEAT_SHIFT);
         end else if (axi_awready) begin
            axi_awvalid <= 1'b0;
         end

         if (word_fire) begin
            words_left <= words_left - ONE;
            if (push) begin
               pack_idx <= '0;
               pack_reg <= '0;
            end else begin
               pack_idx <= pack_idx + IDX_W'(1);
               pack_reg <= beat_data;
            end
         end
         if (push) wr_ptr <= wr_ptr + 1'b1;

         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (w_first) begin
               w_burst_left <= w_beats - ONE;
               w_remaining  <= w_remaining - w_beats;
               w_addr       <= w_addr + (AXI_ADDR_WIDTH'(w_beats) << BEAT_SHIFT);
            end else begin
               w_burst_left <= w_burst_left - ONE;
            end
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_axis_write_core.sv
// tb_axis_write_core: directed table vectors plus hand sequences for packing, backpressure and reset.
`default_nettype none
module tb_axis_write_core;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // default-parameter instance
   logic [31:0] cfg_address, cfg_length, axi_awaddr, axi_wdata, data;
   logic [7:0]  axi_awlen;
   logic cfg_valid, cfg_ready, axi_awready, axi_awvalid, axi_wlast, axi_wvalid, axi_wready, valid, ready;

   axis_write_core dut (
      .clk(clk), .rst(rst),
      .cfg_address(cfg_address), .cfg_length(cfg_length), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .axi_awready(axi_awready), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid),
      .axi_wlast(axi_wlast), .axi_wdata(axi_wdata), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
      .data(data), .valid(valid), .ready(ready)
   );

   // 8-bit stream, 4 words per beat
   logic [31:0] cfg_address_8, cfg_length_8, axi_awaddr_8, axi_wdata_8;
   logic [7:0]  axi_awlen_8, data_8;
   logic cfg_valid_8, cfg_ready_8, axi_awready_8, axi_awvalid_8, axi_wlast_8, axi_wvalid_8, axi_wready_8;
   logic valid_8, ready_8;

   axis_write_core #(.WIDTH_RATIO(4), .CONVERT_SHIFT(2), .DATA_WIDTH(8)) dut8 (
      .clk(clk), .rst(rst),
      .cfg_address(cfg_address_8), .cfg_length(cfg_length_8), .cfg_valid(cfg_valid_8), .cfg_ready(cfg_ready_8),
      .axi_awready(axi_awready_8), .axi_awaddr(axi_awaddr_8), .axi_awlen(axi_awlen_8), .axi_awvalid(axi_awvalid_8),
      .axi_wlast(axi_wlast_8), .axi_wdata(axi_wdata_8), .axi_wvalid(axi_wvalid_8), .axi_wready(axi_wready_8),
      .data(data_8), .valid(valid_8), .ready(ready_8)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   int n_accepted = 0;
   int hold_err = 0;
   bit stall = 1'b0;

   logic [31:0] aw_addr_q[$], w_data_q[$], aw8_addr_q[$], w8_data_q[$];
   logic [7:0]  aw_len_q[$], aw8_len_q[$];
   logic        w_last_q[$], w8_last_q[$];

   typedef struct {
      logic [31:0] addr;
      logic [31:0] len;
      int          nb;
      logic [31:0] a0;
      int          l0;
      logic [31:0] a1;
      int          l1;
   } vec_t;
   vec_t vecs [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Ready patterns change shortly after each rising edge so they are stable at the sampling edge.
   always @(posedge clk) begin
      #2;
      axi_awready = ($urandom_range(0, 3) != 0);
      axi_wready  = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
   end

   logic        aw_pending = 1'b0;
   logic [31:0] held_addr;
   logic [7:0]  held_len;
   always @(negedge clk) begin
      if (rst) begin
         if (axi_awvalid && axi_awready) begin
            aw_addr_q.push_back(axi_awaddr);
            aw_len_q.push_back(axi_awlen);
         end
         if (axi_wvalid && axi_wready) begin
            w_data_q.push_back(axi_wdata);
            w_last_q.push_back(axi_wlast);
         end
         if (valid && ready) n_accepted++;
         if (aw_pending && (!axi_awvalid || axi_awaddr !== held_addr || axi_awlen !== held_len)) hold_err++;
         aw_pending = axi_awvalid && !axi_awready;
         held_addr  = axi_awaddr;
         held_len   = axi_awlen;
         if (axi_awvalid_8 && axi_awready_8) begin
            aw8_addr_q.push_back(axi_awaddr_8);
            aw8_len_q.push_back(axi_awlen_8);
         end
         if (axi_wvalid_8 && axi_wready_8) begin
            w8_data_q.push_back(axi_wdata_8);
            w8_last_q.push_back(axi_wlast_8);
         end
      end else begin
         aw_pending = 1'b0;
      end
   end

   task automatic clear_queues();
      aw_addr_q.delete(); aw_len_q.delete(); w_data_q.delete(); w_last_q.delete();
   endtask

   task automatic send_words(input int n, input logic [31:0] base);
      int t;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         data  = base + k;
         valid = 1'b1;
         t = 0;
         while (!ready && t < 4000) begin
            @(negedge clk);
            t++;
         end
         if (!ready) begin
            n_cmp++; n_fail++;
            $display("FAIL stream_wait: ready still %0b after %0d cycles, expected 1", ready, t);
            break;
         end
         @(posedge clk);
      end
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic issue_cfg(input logic [31:0] addr, input logic [31:0] len);
      @(negedge clk);
      cfg_address = addr;
      cfg_length  = len;
      cfg_valid   = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic wait_done(input int nbeats);
      int t = 0;
      while (!(cfg_ready && w_data_q.size() == nbeats) && t < 20000) begin
         @(negedge clk);
         t++;
      end
      repeat (5) @(negedge clk);
      check("done_beats", w_data_q.size(), nbeats);
      check("done_cfg_ready", cfg_ready, 1);
   endtask

   task automatic check_stream(input string tag, input logic [31:0] base, input int nb, input int l0, input int l1);
      int derr = 0;
      int lerr = 0;
      logic exp_last;
      for (int k = 0; k < w_data_q.size(); k++) begin
         if (w_data_q[k] !== base + k) derr++;
         exp_last = (k == l0) || (nb == 2 && k == l0 + l1 + 1);
         if (w_last_q[k] !== exp_last) lerr++;
      end
      check({tag, "_wdata_errs"}, derr, 0);
      check({tag, "_wlast_errs"}, lerr, 0);
   endtask

   task automatic run_vector(input vec_t v, input logic [31:0] base);
      clear_queues();
      issue_cfg(v.addr, v.len);
      check("cfg_ready_after_accept", cfg_ready, (v.len == 0));
      send_words(int'(v.len), base);
      wait_done(int'(v.len));
      check("aw_count", aw_addr_q.size(), v.nb);
      if (aw_addr_q.size() >= 1) begin
         check("aw0_addr", aw_addr_q[0], v.a0);
         check("aw0_len", aw_len_q[0], v.l0);
      end
      if (v.nb == 2 && aw_addr_q.size() >= 2) begin
         check("aw1_addr", aw_addr_q[1], v.a1);
         check("aw1_len", aw_len_q[1], v.l1);
      end
      check_stream("vec", base, v.nb, v.l0, v.l1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running at %0t, expected $finish", $time);
      $fatal(1);
   end

   initial begin
      cfg_valid = 0; cfg_address = 0; cfg_length = 0; valid = 0; data = 0;
      axi_awready = 0; axi_wready = 0;
      cfg_valid_8 = 0; cfg_address_8 = 0; cfg_length_8 = 0; valid_8 = 0; data_8 = 0;
      axi_awready_8 = 1; axi_wready_8 = 1;

      vecs[0] = '{32'h1000, 4,   1, 32'h1000, 3,   32'h0,    0};
      vecs[1] = '{32'h0,    300, 2, 32'h0,    255, 32'h400,  43};
`ifdef AXIS_WRITE_4K_SPLIT_EN
      vecs[2] = '{32'hF80,  64,  2, 32'hF80,  31,  32'h1000, 31};
      vecs[7] = '{32'hFF0,  8,   2, 32'hFF0,  3,   32'h1000, 3};
`else
      vecs[2] = '{32'hF80,  64,  1, 32'hF80,  63,  32'h0,    0};
      vecs[7] = '{32'hFF0,  8,   1, 32'hFF0,  7,   32'h0,    0};
`endif
      vecs[3] = '{32'h2000, 256, 1, 32'h2000, 255, 32'h0,    0};
      vecs[4] = '{32'h3000, 257, 2, 32'h3000, 255, 32'h3400, 0};
      vecs[5] = '{32'h4000, 1,   1, 32'h4000, 0,   32'h0,    0};
      vecs[6] = '{32'h5000, 0,   0, 32'h0,    0,   32'h0,    0};

      // reset state
      repeat (3) @(negedge clk);
      check("rst_awvalid", axi_awvalid, 0);
      check("rst_wvalid", axi_wvalid, 0);
      check("rst_wlast", axi_wlast, 0);
      check("rst_ready", ready, 0);
      check("rst_awaddr", axi_awaddr, 0);
      check("rst_awlen", axi_awlen, 0);
      check("rst_wdata", axi_wdata, 0);
      check("rst_cfg_ready", cfg_ready, 1);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 8; i++) run_vector(vecs[i], (i + 1) << 20);

      // narrow stream packed four words per beat, last beat zero-padded
      @(negedge clk);
      cfg_address_8 = 32'h100; cfg_length_8 = 6; cfg_valid_8 = 1'b1;
      @(negedge clk);
      cfg_valid_8 = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         int t = 0;
         @(negedge clk);
         data_8  = 8'(k * 17);
         valid_8 = 1'b1;
         while (!ready_8 && t < 100) begin
            @(negedge clk);
            t++;
         end
         @(posedge clk);
      end
      @(negedge clk);
      valid_8 = 1'b0;
      begin
         int t = 0;
         while (!(cfg_ready_8 && w8_data_q.size() == 2) && t < 200) begin
            @(negedge clk);
            t++;
         end
      end
      check("pack_aw_count", aw8_addr_q.size(), 1);
      check("pack_beats", w8_data_q.size(), 2);
      if (aw8_addr_q.size() >= 1) begin
         check("pack_aw_addr", aw8_addr_q[0], 32'h100);
         check("pack_aw_len", aw8_len_q[0], 1);
      end
      if (w8_data_q.size() >= 2) begin
         check("pack_beat0", w8_data_q[0], 32'h44332211);
         check("pack_beat1", w8_data_q[1], 32'h00006655);
         check("pack_wlast0", w8_last_q[0], 0);
         check("pack_wlast1", w8_last_q[1], 1);
      end

      // W backpressure: FIFO fills to 512 beats, then drains in order
      clear_queues();
      stall = 1'b1;
      issue_cfg(32'h10000, 1000);
      n_accepted = 0;
      fork
         send_words(1000, 32'h00A0_0000);
         begin
            repeat (600) @(negedge clk);
            check("full_words_accepted", n_accepted, 512);
            check("full_ready", ready, 0);
            stall = 1'b0;
         end
      join
      wait_done(1000);
      check("bp_aw_count", aw_addr_q.size(), 4);
      if (aw_addr_q.size() >= 4) begin
         check("bp_aw3_addr", aw_addr_q[3], 32'h10C00);
         check("bp_aw3_len", aw_len_q[3], 231);
      end
      begin
         int derr = 0;
         int lerr = 0;
         for (int k = 0; k < w_data_q.size(); k++) begin
            if (w_data_q[k] !== 32'h00A0_0000 + k) derr++;
            if (w_last_q[k] !== (k == 255 || k == 511 || k == 767 || k == 999)) lerr++;
         end
         check("bp_wdata_errs", derr, 0);
         check("bp_wlast_errs", lerr, 0);
      end

      // reset in the middle of a transfer, then a clean command
      clear_queues();
      issue_cfg(32'h0, 300);
      send_words(50, 32'h00B0_0000);
      @(negedge clk);
      check("pre_abort_ready", ready, 1);
      #1 rst = 1'b0;
      #1;
      check("abort_awvalid", axi_awvalid, 0);
      check("abort_wvalid", axi_wvalid, 0);
      check("abort_ready", ready, 0);
      check("abort_cfg_ready", cfg_ready, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_vector(vecs[0], 32'h00C0_0000);

      check("aw_hold_stable_errs", hold_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
